// File: rtl/debounce_pkg.sv
// Shared limits and counter sizing for the switch debounce bank.
package debounce_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT   = 250000;    // 10 ms at 25 MHz
    localparam int unsigned DEFAULT_LONG_PRESS_LIMIT = 25000000;  // 1 s at 25 MHz

    // Bits needed to hold counts 0..limit-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser, debounce filter, press/release/long-press pulses, LED toggle.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT   = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned LONG_PRESS_LIMIT = DEFAULT_LONG_PRESS_LIMIT,
    parameter bit          ACTIVE_LOW       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic led
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_LIMIT);
    localparam int unsigned LP_W = cnt_width(LONG_PRESS_LIMIT + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_LIMIT);
    localparam logic [LP_W-1:0] LP_HIT  = LP_W'(LONG_PRESS_LIMIT - 1);

    logic [1:0]      sync;
    logic [DB_W-1:0] cnt;
    logic [LP_W-1:0] lp_cnt;
    logic            held;

    logic s_c;
    logic accept_c;
    logic press_c;
    logic release_c;
    logic long_c;

    // Normalised level and the events the next edge will register.
    always_comb begin
        s_c       = sync[1] ^ ACTIVE_LOW;
        accept_c  = (cnt == DB_LAST);
        press_c   = accept_c && s_c && !level;
        release_c = accept_c && !s_c && level;
        long_c    = level && !release_c && !held && (lp_cnt == LP_HIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= {2{ACTIVE_LOW}};
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            lp_cnt        <= '0;
            held          <= 1'b0;
            led           <= 1'b0;
        end else begin
            sync          <= {sync[0], raw};
            press         <= press_c;
            release_pulse <= release_c;
            long_press    <= long_c;

            // A glitch back to the current level restarts the count.
            if ((s_c != level) && (cnt < DB_LAST)) begin
                cnt <= cnt + DB_W'(1);
            end else if (accept_c) begin
                level <= s_c;
                cnt   <= '0;
            end else begin
                cnt <= '0;
            end

            if (!level || release_c) begin
                lp_cnt <= '0;
                held   <= 1'b0;
            end else begin
                if (lp_cnt != LP_SAT) begin
                    lp_cnt <= lp_cnt + LP_W'(1);
                end
                if (long_c) begin
                    held <= 1'b1;
                end
            end

            // A release that ends a long press leaves the LED alone.
            if (release_c && !held) begin
                led <= ~led;
            end
        end
    end

endmodule

// File: rtl/debounced_switch_bank.sv
// Bank of independent debounced switch channels driving event pulses and LED toggles.
module debounced_switch_bank
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH           = 4,
    parameter int unsigned DEBOUNCE_LIMIT   = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned LONG_PRESS_LIMIT = DEFAULT_LONG_PRESS_LIMIT,
    parameter bit          ACTIVE_LOW       = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Press,
    output logic [NUM_CH-1:0] o_Release,
    output logic [NUM_CH-1:0] o_Long_Press,
    output logic [NUM_CH-1:0] o_LED
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT   (DEBOUNCE_LIMIT),
            .LONG_PRESS_LIMIT (LONG_PRESS_LIMIT),
            .ACTIVE_LOW       (ACTIVE_LOW)
        ) u_ch (
            .clk           (i_Clk),
            .rst           (i_Rst),
            .raw           (i_Switch[g]),
            .level         (o_Debounced[g]),
            .press         (o_Press[g]),
            .release_pulse (o_Release[g]),
            .long_press    (o_Long_Press[g]),
            .led           (o_LED[g])
        );
    end

endmodule

// File: tb/tb_debounced_switch_bank.sv
// Directed bench: an active-high and an active-low bank share one stimulus and one set of expectations.
module tb_debounced_switch_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic [1:0] sw_n;

    logic [1:0] deb_a, press_a, rel_a, lp_a, led_a;
    logic [1:0] deb_b, press_b, rel_b, lp_b, led_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    assign sw_n = ~sw;

    debounced_switch_bank #(
        .NUM_CH(2), .DEBOUNCE_LIMIT(4), .LONG_PRESS_LIMIT(16), .ACTIVE_LOW(1'b0)
    ) u_dut_hi (
        .i_Clk(clk), .i_Rst(rst), .i_Switch(sw),
        .o_Debounced(deb_a), .o_Press(press_a), .o_Release(rel_a),
        .o_Long_Press(lp_a), .o_LED(led_a)
    );

    debounced_switch_bank #(
        .NUM_CH(2), .DEBOUNCE_LIMIT(4), .LONG_PRESS_LIMIT(16), .ACTIVE_LOW(1'b1)
    ) u_dut_lo (
        .i_Clk(clk), .i_Rst(rst), .i_Switch(sw_n),
        .o_Debounced(deb_b), .o_Press(press_b), .o_Release(rel_b),
        .o_Long_Press(lp_b), .o_LED(led_b)
    );

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b", tag, got, exp);
    endtask

    task automatic expect_all(input string tag, input logic [1:0] deb, input logic [1:0] pr,
                              input logic [1:0] rl, input logic [1:0] lp, input logic [1:0] led);
        check({tag, ".hi.deb"},   deb_a,   deb);
        check({tag, ".hi.press"}, press_a, pr);
        check({tag, ".hi.rel"},   rel_a,   rl);
        check({tag, ".hi.long"},  lp_a,    lp);
        check({tag, ".hi.led"},   led_a,   led);
        check({tag, ".lo.deb"},   deb_b,   deb);
        check({tag, ".lo.press"}, press_b, pr);
        check({tag, ".lo.rel"},   rel_b,   rl);
        check({tag, ".lo.long"},  lp_b,    lp);
        check({tag, ".lo.led"},   led_b,   led);
    endtask

    // Advance past the next rising edge and settle before sampling or driving.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        sw  = 2'b00;
        tick();
        expect_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        rst = 1'b0;
        tick(3);
        expect_all("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Clean press on ch0, held 8 cycles, then released.
        sw = 2'b01;
        tick(5);
        expect_all("s1_pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        expect_all("s1_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        tick();
        expect_all("s1_held", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        sw = 2'b00;
        tick(5);
        expect_all("s1_rel_pre", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        expect_all("s1_rel", 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        tick();
        expect_all("s1_led", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);

        // Bounce on ch1: 1,0,1,0 then stable 1.
        tick();
        sw = 2'b10; tick();
        expect_all("s2_b0", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        sw = 2'b00; tick();
        expect_all("s2_b1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        sw = 2'b10; tick();
        expect_all("s2_b2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        sw = 2'b00; tick();
        expect_all("s2_b3", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        sw = 2'b10;
        tick(5);
        expect_all("s2_pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        tick();
        expect_all("s2_press", 2'b10, 2'b10, 2'b00, 2'b00, 2'b01);
        sw = 2'b00;
        tick(5);
        expect_all("s2_rel_pre", 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
        tick();
        expect_all("s2_rel", 2'b00, 2'b00, 2'b10, 2'b00, 2'b11);

        // Long press on ch0 held 30 cycles.
        tick();
        sw = 2'b01;
        tick(6);
        expect_all("s3_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b11);
        tick(15);
        expect_all("s3_lp_pre", 2'b01, 2'b00, 2'b00, 2'b00, 2'b11);
        tick();
        expect_all("s3_lp", 2'b01, 2'b00, 2'b00, 2'b01, 2'b11);
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_all("s3_norepeat", 2'b01, 2'b00, 2'b00, 2'b00, 2'b11);
        end
        sw = 2'b00;
        tick(5);
        expect_all("s3_rel_pre", 2'b01, 2'b00, 2'b00, 2'b00, 2'b11);
        tick();
        expect_all("s3_rel", 2'b00, 2'b00, 2'b01, 2'b00, 2'b11);
        tick();
        expect_all("s3_led_kept", 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);

        // Reset two counts into a ch0 debounce; input stays pressed.
        tick();
        sw = 2'b01;
        tick(4);
        rst = 1'b1;
        tick();
        expect_all("s5_in_reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick();
        expect_all("s5_discard", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(4);
        expect_all("s5_pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        expect_all("s5_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        sw = 2'b00;
        tick(6);
        expect_all("s5_rel", 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);

        // Both channels pressed together, released separately.
        tick();
        sw = 2'b11;
        tick(6);
        expect_all("s4_press", 2'b11, 2'b11, 2'b00, 2'b00, 2'b01);
        sw = 2'b10;
        tick();
        expect_all("s4_held", 2'b11, 2'b00, 2'b00, 2'b00, 2'b01);
        tick(5);
        expect_all("s4_rel0", 2'b10, 2'b00, 2'b01, 2'b00, 2'b00);
        sw = 2'b00;
        tick(6);
        expect_all("s4_rel1", 2'b00, 2'b00, 2'b10, 2'b00, 2'b10);
        tick();
        expect_all("s4_end", 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debounced_switch_bank.md
Name: debounced_switch_bank

Overview:
Multi-channel successor to the single-switch debounce-plus-LED-toggle top. Each of NUM_CH raw switch inputs goes through a 2-flop synchroniser and a parametrised debounce filter. The debounced level then drives press/release/long-press event pulses and a per-channel LED toggle register. The block sits between the board switch pins and the LED pins and feeds event pulses to downstream UI logic.

Parameters:
NUM_CH, 4, number of independent switch channels (1..8).
DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); must be >= 2.
LONG_PRESS_LIMIT, 25000000, cycles the debounced level must stay pressed to raise a long press (1 s at 25 MHz); must be > DEBOUNCE_LIMIT.
ACTIVE_LOW, 0, 1 = raw switch reads 0 when pressed; inversion happens after the synchroniser.

Ports:
i_Clk  in  1  system clock; the only clock.
i_Rst  in  1  synchronous, active-high reset.
i_Switch  in  NUM_CH  raw bouncy switch inputs, asynchronous.
o_Debounced  out  NUM_CH  debounced level, 1 = pressed.
o_Press  out  NUM_CH  1-cycle pulse on accepted press.
o_Release  out  NUM_CH  1-cycle pulse on accepted release.
o_Long_Press  out  NUM_CH  1-cycle pulse when a press has lasted LONG_PRESS_LIMIT cycles.
o_LED  out  NUM_CH  per-channel toggle state.

Behaviour:
- Reset: all synchroniser flops, counters, held flags and outputs go to 0 on the first rising i_Clk edge with i_Rst=1. Synchroniser flops load the inactive raw level (1 if ACTIVE_LOW). Reset mid-press discards the partial count. A switch held through reset is re-debounced from zero and produces o_Press DEBOUNCE_LIMIT+2 cycles after i_Rst falls.
- Synchroniser: 2 flops per channel, then polarity normalisation. The result is s.
- Debounce, per channel, with counter cnt:
  - if s != o_Debounced and cnt < DEBOUNCE_LIMIT-1: cnt++;
  - else if cnt == DEBOUNCE_LIMIT-1: o_Debounced <= s, cnt <= 0;
  - else cnt <= 0.
  - Any glitch back to the current level restarts the count.
- Latency: a clean raw edge at cycle 0 is reflected on o_Debounced at cycle DEBOUNCE_LIMIT+2.
- o_Press and o_Release are registered in the same cycle o_Debounced changes (0->1 and 1->0 respectively). Never both high in one channel and cycle.
- Long press:
  - lp_cnt increments while o_Debounced=1 and saturates at LONG_PRESS_LIMIT.
  - When lp_cnt reaches LONG_PRESS_LIMIT-1 while still pressed, o_Long_Press pulses once and the held flag is set.
  - No repeat pulses while held.
  - lp_cnt and the held flag clear on release.
- LED: o_LED toggles in the cycle o_Release is asserted, only if the held flag is clear. A long press never toggles the LED.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Counter widths: $clog2(DEBOUNCE_LIMIT) and $clog2(LONG_PRESS_LIMIT+1). No wrap-around is permitted; counters saturate or clear as described.

Decomposition:
- Package debounce_pkg holds the default limit constants for a 25 MHz clock and a width helper function returning counter width from a limit.
- One sub-module, debounce_channel, contains the synchroniser, debounce counter, event pulses, long-press counter and LED toggle for one channel.
- The top instantiates debounce_channel NUM_CH times in a generate loop.

Test Plan:
Run all scenarios with NUM_CH=2, DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=16, ACTIVE_LOW=0.
1. Clean press on ch0 at cycle 10, held for 8 cycles -> o_Debounced[0] rises at cycle 16 with o_Press[0] high for exactly cycle 16; release at cycle 18 -> o_Release[0] pulses at cycle 24 and o_LED[0] = 1 from cycle 24.
2. Bounce on ch1: 1,0,1,0 alternating each cycle, then stable 1 -> no event during the bounce; o_Press[1] fires 6 cycles after the last edge.
3. Long press on ch0, held 30 cycles -> exactly one o_Long_Press[0] pulse, 16 cycles after o_Press[0]; on release o_Release[0] pulses and o_LED[0] is unchanged.
4. Both channels pressed in the same cycle -> o_Press = 2'b11 in a single cycle; the two release-driven toggles are independent.
5. i_Rst asserted for 1 cycle while ch0 is 2 cycles into debouncing, input held at 1 -> all outputs 0 during reset; o_Press[0] arrives 6 cycles after i_Rst falls.
6. Re-run scenario 1 with ACTIVE_LOW=1 and an inverted stimulus -> identical output waveforms.
